// File: rtl/board_pkg.sv
// Shared types and constants for the N x N, K-in-a-row board game engine.
// Provides cell codes, game-state codes, FSM state enum, the four win-check
// direction deltas, pixel colour constants and a player-to-cell helper.
package board_pkg;

  // Board storage is always sized for the largest supported board.
  localparam int unsigned MAXN = 8;

  typedef logic [1:0] cell_t;
  localparam cell_t CELL_EMPTY = 2'b00;
  localparam cell_t CELL_P0    = 2'b01;
  localparam cell_t CELL_P1    = 2'b10;

  typedef logic [1:0] gs_t;
  localparam gs_t GS_PLAY = 2'b00;
  localparam gs_t GS_WIN0 = 2'b01;
  localparam gs_t GS_WIN1 = 2'b10;
  localparam gs_t GS_DRAW = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_VB,
    S_CHECK,
    S_DONE
  } state_t;

  // Signed probe coordinate: must hold -1 .. MAXN for the bounds test.
  typedef logic signed [4:0] coord_t;

  // Directions in check order: H(1,0), V(0,1), D(1,1), A(1,-1).
  localparam coord_t DIR_DX [4] = '{5'sd1, 5'sd0, 5'sd1, 5'sd1};
  localparam coord_t DIR_DY [4] = '{5'sd0, 5'sd1, 5'sd1, -5'sd1};

  typedef logic [2:0] rgb_t;
  localparam rgb_t WHITE = 3'b111;
  localparam rgb_t BLACK = 3'b000;
  localparam rgb_t RED   = 3'b100;
  localparam rgb_t BLUE  = 3'b001;
  localparam rgb_t GREEN = 3'b010;

  function automatic cell_t player_cell(input logic p);
    return p ? CELL_P1 : CELL_P0;
  endfunction

endpackage

// File: rtl/board_pixel_map.sv
// Combinational pixel-to-board mapper.
// Ports:
//   row, col   : current pixel position
//   in_board   : pixel lies inside the N*CELL square starting at ORIGIN
//   grid_line  : pixel is on a cell's first row/column or the board's last row/column
//   inner      : pixel offset within its cell is in [MARGIN, CELL-MARGIN) on both axes
//   cell_x/y   : cell index (valid only when in_board)
module board_pixel_map #(
  parameter int unsigned N      = 3,
  parameter int unsigned CELL   = 100,
  parameter int unsigned ORIGIN = 50,
  parameter int unsigned MARGIN = 12
) (
  input  logic [31:0] row,
  input  logic [31:0] col,
  output logic        in_board,
  output logic        grid_line,
  output logic        inner,
  output logic [2:0]  cell_x,
  output logic [2:0]  cell_y
);

  localparam logic [31:0] LO = 32'(ORIGIN);
  localparam logic [31:0] HI = 32'(ORIGIN + N * CELL);

  logic [31:0] off_x;
  logic [31:0] off_y;
  logic        in_x;
  logic        in_y;

  always_comb begin
    cell_x = '0;
    cell_y = '0;
    off_x  = col - LO;
    off_y  = row - LO;
    // Compare chain against each cell's left/top boundary; last match wins.
    for (int unsigned i = 1; i < N; i++) begin
      if (col >= 32'(ORIGIN + i * CELL)) begin
        cell_x = 3'(i);
        off_x  = col - 32'(ORIGIN + i * CELL);
      end
      if (row >= 32'(ORIGIN + i * CELL)) begin
        cell_y = 3'(i);
        off_y  = row - 32'(ORIGIN + i * CELL);
      end
    end
    in_x      = (col >= LO) && (col < HI);
    in_y      = (row >= LO) && (row < HI);
    in_board  = in_x && in_y;
    grid_line = (off_x == '0) || (off_y == '0) ||
                (col == HI - 32'd1) || (row == HI - 32'd1);
    inner     = (off_x >= 32'(MARGIN)) && (off_x < 32'(CELL - MARGIN)) &&
                (off_y >= 32'(MARGIN)) && (off_y < 32'(CELL - MARGIN));
  end

endmodule

// File: rtl/board_game_ctrl.sv
// N x N, K-in-a-row two-player game engine with VGA pixel colouring.
// Ports:
//   CLK, RST          : clock, asynchronous active-low reset
//   new_game          : synchronous clear, highest priority after RST
//   move_valid/x/y    : move request; accepted when move_ready is high
//   move_ready        : engine idle and game still in play
//   move_reject       : one-cycle pulse after an illegal accepted move
//   player            : player to move (0 = P0, 1 = P1)
//   game_state        : 00 playing, 01 P0 won, 10 P1 won, 11 draw
//   vnotactive        : vertical blanking; board writes wait for it
//   row, col          : pixel position from the VGA timing generator
//   red, green, blue  : registered pixel colour (1-cycle latency)
module board_game_ctrl
  import board_pkg::*;
#(
  parameter int unsigned N      = 3,
  parameter int unsigned K      = 3,
  parameter int unsigned CELL   = 100,
  parameter int unsigned ORIGIN = 50,
  parameter int unsigned MARGIN = 12
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        new_game,
  input  logic        move_valid,
  input  logic [2:0]  move_x,
  input  logic [2:0]  move_y,
  output logic        move_ready,
  output logic        move_reject,
  output logic        player,
  output logic [1:0]  game_state,
  input  logic        vnotactive,
  input  logic [31:0] row,
  input  logic [31:0] col,
  output logic        red,
  output logic        green,
  output logic        blue
);

  state_t     state_q;
  logic       player_q;
  gs_t        gs_q;
  logic [6:0] moves_q;
  logic [2:0] mx_q;
  logic [2:0] my_q;
  logic       reject_q;
  cell_t      board_q [MAXN][MAXN];
  logic [1:0] dir_q;
  logic       neg_q;
  logic [3:0] cnt_q;
  coord_t     px_q;
  coord_t     py_q;
  rgb_t       rgb_q;
  rgb_t       rgb_d;

  coord_t     mx_s;
  coord_t     my_s;
  coord_t     dx;
  coord_t     dy;
  logic [1:0] dir_nx;
  logic       probe_in;
  logic       probe_hit;
  cell_t      probe_cell;
  logic       mv_bad;

  assign move_ready  = (state_q == S_IDLE) && (gs_q == GS_PLAY);
  assign move_reject = reject_q;
  assign player      = player_q;
  assign game_state  = gs_q;
  assign {red, green, blue} = rgb_q;

  assign mx_s   = coord_t'({2'b00, mx_q});
  assign my_s   = coord_t'({2'b00, my_q});
  assign dx     = DIR_DX[dir_q];
  assign dy     = DIR_DY[dir_q];
  assign dir_nx = dir_q + 2'd1;

  always_comb begin
    probe_in   = !px_q[4] && !py_q[4] &&
                 (px_q[3:0] < 4'(N)) && (py_q[3:0] < 4'(N));
    probe_cell = board_q[py_q[2:0]][px_q[2:0]];
    probe_hit  = probe_in && (probe_cell == player_cell(player_q));
    mv_bad     = ({1'b0, move_x} >= 4'(N)) || ({1'b0, move_y} >= 4'(N)) ||
                 (board_q[move_y][move_x] != CELL_EMPTY);
  end

  // Game FSM. CHECK walks one cell per cycle: positive side of the current
  // direction, then the negative side, restarting the count per direction.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      player_q <= 1'b0;
      gs_q     <= GS_PLAY;
      moves_q  <= '0;
      mx_q     <= '0;
      my_q     <= '0;
      reject_q <= 1'b0;
      board_q  <= '{default: CELL_EMPTY};
      dir_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= 4'd1;
      px_q     <= '0;
      py_q     <= '0;
    end else if (new_game) begin
      state_q  <= S_IDLE;
      player_q <= 1'b0;
      gs_q     <= GS_PLAY;
      moves_q  <= '0;
      reject_q <= 1'b0;
      board_q  <= '{default: CELL_EMPTY};
      dir_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= 4'd1;
    end else begin
      reject_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (move_valid && move_ready) begin
            if (mv_bad) begin
              reject_q <= 1'b1;
            end else begin
              mx_q    <= move_x;
              my_q    <= move_y;
              state_q <= S_WAIT_VB;
            end
          end
        end
        S_WAIT_VB: begin
          if (vnotactive) begin
            board_q[my_q][mx_q] <= player_cell(player_q);
            moves_q <= moves_q + 7'd1;
            dir_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= 4'd1;
            px_q    <= mx_s + DIR_DX[0];
            py_q    <= my_s + DIR_DY[0];
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (probe_hit) begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q + 4'd1 == 4'(K)) begin
              gs_q    <= player_q ? GS_WIN1 : GS_WIN0;
              state_q <= S_DONE;
            end else if (neg_q) begin
              px_q <= px_q - dx;
              py_q <= py_q - dy;
            end else begin
              px_q <= px_q + dx;
              py_q <= py_q + dy;
            end
          end else if (!neg_q) begin
            neg_q <= 1'b1;
            px_q  <= mx_s - dx;
            py_q  <= my_s - dy;
          end else if (dir_q == 2'd3) begin
            if (moves_q == 7'(N * N)) begin
              gs_q    <= GS_DRAW;
              state_q <= S_DONE;
            end else begin
              player_q <= !player_q;
              state_q  <= S_IDLE;
            end
          end else begin
            dir_q <= dir_nx;
            neg_q <= 1'b0;
            cnt_q <= 4'd1;
            px_q  <= mx_s + DIR_DX[dir_nx];
            py_q  <= my_s + DIR_DY[dir_nx];
          end
        end
        S_DONE: ;
      endcase
    end
  end

  logic       pix_in;
  logic       pix_grid;
  logic       pix_inner;
  logic [2:0] pix_x;
  logic [2:0] pix_y;
  cell_t      pix_cell;

  board_pixel_map #(
    .N      (N),
    .CELL   (CELL),
    .ORIGIN (ORIGIN),
    .MARGIN (MARGIN)
  ) u_pixel_map (
    .row       (row),
    .col       (col),
    .in_board  (pix_in),
    .grid_line (pix_grid),
    .inner     (pix_inner),
    .cell_x    (pix_x),
    .cell_y    (pix_y)
  );

  always_comb begin
    rgb_d    = WHITE;
    pix_cell = board_q[pix_y][pix_x];
    if (pix_in) begin
      if (pix_grid) begin
        rgb_d = BLACK;
      end else if (pix_inner) begin
        // Last placed stone is highlighted once the game is decided.
        if (pix_cell != CELL_EMPTY && gs_q != GS_PLAY &&
            pix_x == mx_q && pix_y == my_q) begin
          rgb_d = GREEN;
        end else if (pix_cell == CELL_P0) begin
          rgb_d = RED;
        end else if (pix_cell == CELL_P1) begin
          rgb_d = BLUE;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rgb_q <= WHITE;
    end else begin
      rgb_q <= rgb_d;
    end
  end

endmodule

// File: tb/tb_board_game_ctrl.sv
// Scoreboard bench for board_game_ctrl: a 3x3/K=3 instance and a 5x5/K=4
// instance share stimulus, selected by sel; a negedge monitor pops expected
// game_state changes, reject pulses and pixel colours as the DUT presents them.
module tb_board_game_ctrl;

  localparam logic [2:0] C_WHITE = 3'b111;
  localparam logic [2:0] C_BLACK = 3'b000;
  localparam logic [2:0] C_RED   = 3'b100;
  localparam logic [2:0] C_BLUE  = 3'b001;
  localparam logic [2:0] C_GREEN = 3'b010;

  logic        CLK;
  logic        RST;
  logic        new_game;
  logic        move_valid;
  logic [2:0]  move_x;
  logic [2:0]  move_y;
  logic        vnotactive;
  logic [31:0] row;
  logic [31:0] col;
  logic        sel;
  logic        pix_req;

  logic        mv3, mv5;
  logic        rdy3, rdy5, rej3, rej5, pl3, pl5;
  logic [1:0]  gs3, gs5;
  logic        r3, g3, b3, r5, g5, b5;

  logic        move_ready, move_reject, player;
  logic [1:0]  game_state;
  logic [2:0]  rgb;

  assign mv3         = move_valid && !sel;
  assign mv5         = move_valid && sel;
  assign move_ready  = sel ? rdy5 : rdy3;
  assign move_reject = sel ? rej5 : rej3;
  assign player      = sel ? pl5 : pl3;
  assign game_state  = sel ? gs5 : gs3;
  assign rgb         = sel ? {r5, g5, b5} : {r3, g3, b3};

  board_game_ctrl #(.N(3), .K(3), .CELL(100), .ORIGIN(50), .MARGIN(12)) dut3 (
    .CLK(CLK), .RST(RST), .new_game(new_game), .move_valid(mv3),
    .move_x(move_x), .move_y(move_y), .move_ready(rdy3), .move_reject(rej3),
    .player(pl3), .game_state(gs3), .vnotactive(vnotactive),
    .row(row), .col(col), .red(r3), .green(g3), .blue(b3)
  );

  board_game_ctrl #(.N(5), .K(4), .CELL(100), .ORIGIN(50), .MARGIN(12)) dut5 (
    .CLK(CLK), .RST(RST), .new_game(new_game), .move_valid(mv5),
    .move_x(move_x), .move_y(move_y), .move_ready(rdy5), .move_reject(rej5),
    .player(pl5), .game_state(gs5), .vnotactive(vnotactive),
    .row(row), .col(col), .red(r5), .green(g5), .blue(b5)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_pass  = 0;
  int n_total = 0;

  logic [1:0]  gs_exp_q  [$];
  logic        rej_exp_q [$];
  logic [2:0]  pix_exp_q [$];
  string       pix_name_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compares whenever the DUT presents an output event.
  logic       pend_pix = 1'b0;
  logic       rej_chk  = 1'b0;
  logic [1:0] gs_prev  = 2'b00;
  always @(negedge CLK) begin
    if (pend_pix && pix_exp_q.size() > 0) begin
      check(pix_name_q.pop_front(), 32'(rgb), 32'(pix_exp_q.pop_front()));
    end
    pend_pix = pix_req;
    if (rej_chk) check("rej_width", 32'(move_reject), 32'd0);
    rej_chk = move_reject;
    if (move_reject) begin
      if (rej_exp_q.size() == 0) check("rej_unexpected", 32'd1, 32'd0);
      else check("rej_player", 32'(player), 32'(rej_exp_q.pop_front()));
    end
    if (game_state !== gs_prev) begin
      if (gs_exp_q.size() == 0) check("gs_unexpected", 32'(game_state), 32'(gs_prev));
      else check("game_state", 32'(game_state), 32'(gs_exp_q.pop_front()));
    end
    gs_prev = game_state;
  end

  function automatic logic [31:0] ctr(input int i);
    return 32'(50 + i * 100 + 50);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pixrc(input logic [31:0] r, input logic [31:0] c,
                       input logic [2:0] exp, input string nm);
    row = r;
    col = c;
    pix_exp_q.push_back(exp);
    pix_name_q.push_back(nm);
    pix_req = 1'b1;
    tick();
    pix_req = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input logic [2:0] exp, input string nm);
    pixrc(ctr(y), ctr(x), exp, nm);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!move_ready && n < 60) begin
      tick();
      n++;
    end
    check("wait_ready", 32'(move_ready), 32'd1);
  endtask

  task automatic send(input int x, input int y);
    move_x = 3'(x);
    move_y = 3'(y);
    move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
  endtask

  task automatic play(input int x, input int y);
    wait_ready();
    send(x, y);
  endtask

  task automatic wait_gs(output int cyc);
    cyc = 0;
    while (game_state == 2'b00 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic pulse_new_game();
    gs_exp_q.push_back(2'b00);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  int cyc;

  initial begin
    sel = 1'b0; RST = 1'b1; new_game = 1'b0; move_valid = 1'b0;
    move_x = '0; move_y = '0; vnotactive = 1'b1; row = '0; col = '0; pix_req = 1'b0;
    #1 RST = 1'b0;
    repeat (2) tick();
    check("rst_ready",  32'(move_ready), 32'd1);
    check("rst_rgb",    32'(rgb),        32'(C_WHITE));
    check("rst_player", 32'(player),     32'd0);
    check("rst_gs",     32'(game_state), 32'd0);
    RST = 1'b1;
    tick();

    // Reset applied while the engine is checking a freshly written move.
    play(1, 1);
    tick();
    check("midcheck_ready", 32'(move_ready), 32'd0);
    RST = 1'b0;
    #1;
    check("midrst_rgb",    32'(rgb),        32'(C_WHITE));
    check("midrst_gs",     32'(game_state), 32'd0);
    check("midrst_player", 32'(player),     32'd0);
    check("midrst_ready",  32'(move_ready), 32'd1);
    #3 RST = 1'b1;
    tick();
    pix(0, 0, C_WHITE, "rst_pix00");
    pix(1, 1, C_WHITE, "rst_pix11");

    // Game 1: P0 wins on row 0.
    play(0, 0);
    play(0, 1);
    play(1, 0);
    wait_ready();
    vnotactive = 1'b0;
    send(1, 1);
    repeat (3) begin
      pix(1, 1, C_WHITE, "vb_hold_pix");
      check("vb_hold_ready", 32'(move_ready), 32'd0);
    end
    vnotactive = 1'b1;
    pix(1, 1, C_WHITE, "vb_edge_pix");
    pix(1, 1, C_BLUE,  "vb_write_pix");

    wait_ready();
    check("pre_rej_player", 32'(player), 32'd0);
    rej_exp_q.push_back(1'b0);
    send(0, 0);
    repeat (2) tick();
    rej_exp_q.push_back(1'b0);
    send(3, 0);
    repeat (2) tick();
    check("rej_player_kept", 32'(player), 32'd0);
    check("rej_ready_kept",  32'(move_ready), 32'd1);
    pix(0, 0, C_RED, "rej_board_00");
    pix(0, 1, C_BLUE, "rej_board_01");

    // Grid and margin boundaries around cell (0,0).
    pixrc(32'd100, 32'd49,  C_WHITE, "edge_outside");
    pixrc(32'd100, 32'd50,  C_BLACK, "edge_left_grid");
    pixrc(32'd100, 32'd150, C_BLACK, "edge_cell_grid");
    pixrc(32'd100, 32'd349, C_BLACK, "edge_outer_grid");
    pixrc(32'd100, 32'd350, C_WHITE, "edge_past_board");
    pixrc(32'd100, 32'd61,  C_WHITE, "margin_below");
    pixrc(32'd100, 32'd62,  C_RED,   "margin_first");
    pixrc(32'd100, 32'd137, C_RED,   "margin_last");
    pixrc(32'd100, 32'd138, C_WHITE, "margin_past");

    wait_ready();
    gs_exp_q.push_back(2'b01);
    send(2, 0);
    wait_gs(cyc);
    check("win_latency_ok", 32'(cyc <= 18), 32'd1);
    check("win_ready", 32'(move_ready), 32'd0);
    pix(2, 0, C_GREEN, "win_last_pix");
    pix(0, 0, C_RED,   "win_p0_pix");
    pix(0, 1, C_BLUE,  "win_p1_pix");
    send(2, 2);
    repeat (2) tick();
    check("done_gs_hold", 32'(game_state), 32'd1);
    pix(2, 2, C_WHITE, "done_ignored_pix");

    pulse_new_game();
    check("ng_player", 32'(player), 32'd0);
    check("ng_ready",  32'(move_ready), 32'd1);
    pix(0, 0, C_WHITE, "ng_pix00");
    pix(2, 0, C_WHITE, "ng_pix20");

    // new_game while a move waits for blanking drops the move.
    vnotactive = 1'b0;
    play(0, 0);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    vnotactive = 1'b1;
    tick();
    check("ng_wait_ready", 32'(move_ready), 32'd1);
    pix(0, 0, C_WHITE, "ng_wait_pix");

    // Game 2: draw X O X / X O O / O X X.
    play(0, 0); play(1, 0); play(2, 0); play(1, 1);
    play(0, 1); play(2, 1); play(1, 2); play(0, 2);
    wait_ready();
    gs_exp_q.push_back(2'b11);
    send(2, 2);
    wait_gs(cyc);
    check("draw_latency_ok", 32'(cyc <= 18), 32'd1);
    check("draw_ready", 32'(move_ready), 32'd0);
    pix(2, 2, C_GREEN, "draw_last_pix");
    pix(1, 0, C_BLUE,  "draw_p1_pix");
    pulse_new_game();

    // Game 3 on the 5x5, K=4 instance: P0 main diagonal.
    sel = 1'b1;
    tick();
    play(0, 0); play(4, 0); play(1, 1); play(4, 1);
    play(2, 2); play(4, 2);
    wait_ready();
    check("n5_player", 32'(player), 32'd0);
    gs_exp_q.push_back(2'b01);
    send(3, 3);
    wait_gs(cyc);
    check("n5_latency_ok", 32'(cyc <= 26), 32'd1);
    pix(3, 3, C_GREEN, "n5_last_pix");
    pix(0, 0, C_RED,   "n5_p0_pix");
    pix(4, 0, C_BLUE,  "n5_p1_pix");
    pulse_new_game();
    check("n5_ng_player", 32'(player), 32'd0);
    check("n5_ng_ready",  32'(move_ready), 32'd1);
    pix(0, 0, C_WHITE, "n5_ng_pix");

    repeat (3) tick();
    check("gs_queue_drained",  32'(gs_exp_q.size()),  32'd0);
    check("rej_queue_drained", 32'(rej_exp_q.size()), 32'd0);
    check("pix_queue_drained", 32'(pix_exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
